// File: rtl/cordic_req_sched.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | cordic_req_sched                                                         |
// | Round-robin issue of requester ops into the shared CORDIC pipeline, with |
// | an id/select tag pipe that routes each tail result back to its owner.    |
// | Optional: CORDIC_SCHED_STATS_EN adds per-requester accept counters.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module cordic_req_sched #(
    parameter int N_REQ    = 4,
    parameter int ID_W     = 2,
    parameter int PIPE_LAT = 18
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [16*N_REQ-1:0]   req_angle,
    input  logic [16*N_REQ-1:0]   req_another,
    input  logic [4*N_REQ-1:0]    req_select,
    input  logic                  hold,
    output logic                  cordic_valid,
    output logic [15:0]           cordic_angle,
    output logic [15:0]           cordic_another,
    output logic [3:0]            cordic_select,
    input  logic                  res_valid_in,
    input  logic [31:0]           res_x,
    input  logic [31:0]           res_y,
    input  logic [31:0]           res_angle,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [31:0]           rsp_x,
    output logic [31:0]           rsp_y,
    output logic [31:0]           rsp_angle,
    output logic [3:0]            rsp_select,
    output logic                  busy,
`ifdef CORDIC_SCHED_STATS_EN
    output logic [16*N_REQ-1:0]   stat_cnt,
`endif
    output logic                  err_orphan
);

    localparam int MASK_W = $clog2(PIPE_LAT + 1);
    localparam logic [MASK_W-1:0] c_mask_init = MASK_W'(PIPE_LAT);

    logic [ID_W-1:0]   r_ptr;
    logic              r_cv;
    logic [15:0]       r_ca;
    logic [15:0]       r_co;
    logic [3:0]        r_cs;

    logic [PIPE_LAT-1:0] r_tag_v;
    logic [ID_W-1:0]     r_tag_id  [PIPE_LAT];
    logic [3:0]          r_tag_sel [PIPE_LAT];
    logic                r_tail_v;
    logic [ID_W-1:0]     r_tail_id;
    logic [3:0]          r_tail_sel;

    logic [N_REQ-1:0]  r_rsp_valid;
    logic [31:0]       r_rx;
    logic [31:0]       r_ry;
    logic [31:0]       r_ra;
    logic [3:0]        r_rs;
    logic              r_err;
    logic [MASK_W-1:0] r_mask;

    logic              w_found;
    logic [ID_W-1:0]   w_gid;
    int                w_idx;
    logic              w_accept;
    logic [ID_W-1:0]   w_ptr_nxt;
    logic              w_ret;
    logic              w_orphan;

    // Round-robin search starting at the pointer, wrapping at N_REQ.
    always_comb begin
        w_found = 1'b0;
        w_gid   = '0;
        w_idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= N_REQ) begin
                w_idx = w_idx - N_REQ;
            end
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_gid   = ID_W'(w_idx);
            end
        end
    end

    assign w_accept  = w_found & ~hold & rst_n;
    assign w_ptr_nxt = (int'(w_gid) == N_REQ - 1) ? '0 : w_gid + ID_W'(1);

    always_comb begin
        req_ready = '0;
        if (w_accept) begin
            req_ready[w_gid] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
            r_cv  <= 1'b0;
            r_ca  <= '0;
            r_co  <= '0;
            r_cs  <= '0;
        end else begin
            r_cv <= w_accept;
            if (w_accept) begin
                r_ptr <= w_ptr_nxt;
                r_ca  <= req_angle[16*w_gid +: 16];
                r_co  <= req_another[16*w_gid +: 16];
                r_cs  <= req_select[4*w_gid +: 4];
            end
        end
    end

    // The extra tail stage lines the tag up with the cycle res_valid_in arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_v    <= '0;
            r_tail_v   <= 1'b0;
            r_tail_id  <= '0;
            r_tail_sel <= '0;
            for (int k = 0; k < PIPE_LAT; k++) begin
                r_tag_id[k]  <= '0;
                r_tag_sel[k] <= '0;
            end
        end else begin
            r_tag_v[0]   <= w_accept;
            r_tag_id[0]  <= w_gid;
            r_tag_sel[0] <= req_select[4*w_gid +: 4];
            for (int k = 1; k < PIPE_LAT; k++) begin
                r_tag_v[k]   <= r_tag_v[k-1];
                r_tag_id[k]  <= r_tag_id[k-1];
                r_tag_sel[k] <= r_tag_sel[k-1];
            end
            r_tail_v   <= r_tag_v[PIPE_LAT-1];
            r_tail_id  <= r_tag_id[PIPE_LAT-1];
            r_tail_sel <= r_tag_sel[PIPE_LAT-1];
        end
    end

    assign w_ret    = res_valid_in & r_tail_v;
    assign w_orphan = (res_valid_in ^ r_tail_v) & (r_mask == '0);

    // Mask covers stale results still draining from the unreset pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= '0;
            r_rx        <= '0;
            r_ry        <= '0;
            r_ra        <= '0;
            r_rs        <= '0;
            r_err       <= 1'b0;
            r_mask      <= c_mask_init;
        end else begin
            r_rsp_valid <= w_ret ? (N_REQ'(1) << r_tail_id) : '0;
            if (w_ret) begin
                r_rx <= res_x;
                r_ry <= res_y;
                r_ra <= res_angle;
                r_rs <= r_tail_sel;
            end
            if (w_orphan) begin
                r_err <= 1'b1;
            end
            if (r_mask != '0) begin
                r_mask <= r_mask - MASK_W'(1);
            end
        end
    end

`ifdef CORDIC_SCHED_STATS_EN
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stat
            logic [15:0] r_cnt;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (w_accept && (w_gid == ID_W'(gi)) && (r_cnt != 16'hFFFF)) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
            assign stat_cnt[16*gi +: 16] = r_cnt;
        end
    endgenerate
`endif

    assign cordic_valid   = r_cv;
    assign cordic_angle   = r_ca;
    assign cordic_another = r_co;
    assign cordic_select  = r_cs;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_x          = r_rx;
    assign rsp_y          = r_ry;
    assign rsp_angle      = r_ra;
    assign rsp_select     = r_rs;
    assign busy           = (|r_tag_v) | r_tail_v;
    assign err_orphan     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cordic_req_sched.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_cordic_req_sched                                                      |
// | Self-checking bench: grant table, directed corner sequences, random run. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_cordic_req_sched;

    localparam int N    = 4;
    localparam int L    = 18;
    localparam int RING = 64;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [16*N-1:0] req_angle;
    logic [16*N-1:0] req_another;
    logic [4*N-1:0]  req_select;
    logic            hold;
    logic            cordic_valid;
    logic [15:0]     cordic_angle;
    logic [15:0]     cordic_another;
    logic [3:0]      cordic_select;
    logic            res_valid_in;
    logic [31:0]     res_x, res_y, res_angle;
    logic [N-1:0]    rsp_valid;
    logic [31:0]     rsp_x, rsp_y, rsp_angle;
    logic [3:0]      rsp_select;
    logic            busy;
    logic            err_orphan;
`ifdef CORDIC_SCHED_STATS_EN
    logic [16*N-1:0] stat_cnt;
`endif

    cordic_req_sched #(.N_REQ(N), .ID_W(2), .PIPE_LAT(L)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_angle(req_angle), .req_another(req_another), .req_select(req_select),
        .hold(hold),
        .cordic_valid(cordic_valid), .cordic_angle(cordic_angle),
        .cordic_another(cordic_another), .cordic_select(cordic_select),
        .res_valid_in(res_valid_in), .res_x(res_x), .res_y(res_y), .res_angle(res_angle),
        .rsp_valid(rsp_valid), .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_angle(rsp_angle),
        .rsp_select(rsp_select), .busy(busy),
`ifdef CORDIC_SCHED_STATS_EN
        .stat_cnt(stat_cnt),
`endif
        .err_orphan(err_orphan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    endtask

    // Stimulus for the next cycle
    logic         d_rst_n;
    logic         d_hold;
    logic         d_force;
    logic [3:0]   d_valid;
    logic [15:0]  d_ang [N];
    logic [15:0]  d_oth [N];
    logic [3:0]   d_sel [N];

    // Reference model state: fake pipe (survives reset) and expected responses
    int           gcyc;
    int           m_ptr, m_since, last_acc;
    logic [15:0]  m_ang, m_oth;
    logic [3:0]   m_sel, m_rsp, m_rsel;
    logic         m_cv, m_err;
    logic [31:0]  m_x, m_y, m_a;
    bit           inj_v [RING];
    logic [31:0]  inj_x [RING], inj_y [RING], inj_a [RING];
    bit           exp_v [RING];
    int           exp_id [RING];
    logic [3:0]   exp_sel [RING];
    int           acc_cnt [N];
    logic [3:0]   a_ready;
    bit           rec;
    logic [3:0]   rsp_q [$];

    task automatic cycle();
        int e, slot, g, t;
        @(negedge clk);
        e    = gcyc + 1;
        slot = e % RING;
        if (d_force) begin
            inj_v[slot] = 1'b1;
            inj_x[slot] = $urandom; inj_y[slot] = $urandom; inj_a[slot] = $urandom;
        end
        rst_n     = d_rst_n;
        hold      = d_hold;
        req_valid = d_valid;
        for (int i = 0; i < N; i++) begin
            req_angle[16*i +: 16]   = d_ang[i];
            req_another[16*i +: 16] = d_oth[i];
            req_select[4*i +: 4]    = d_sel[i];
        end
        res_valid_in = inj_v[slot];
        res_x = inj_x[slot]; res_y = inj_y[slot]; res_angle = inj_a[slot];
        g = -1;
        if (d_rst_n && !d_hold)
            for (int k = 0; k < N; k++)
                if (g < 0 && d_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        #1;
        a_ready = req_ready;
        chk("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        if (d_rst_n) begin
            if ((inj_v[slot] != exp_v[slot]) && m_since >= L) m_err = 1'b1;
            if (inj_v[slot] && exp_v[slot]) begin
                m_rsp = 4'(1 << exp_id[slot]);
                m_x = inj_x[slot]; m_y = inj_y[slot]; m_a = inj_a[slot];
                m_rsel = exp_sel[slot];
            end else begin
                m_rsp = '0;
            end
            m_since++;
            m_cv = (g >= 0);
            if (g >= 0) begin
                m_ptr = (g + 1) % N;
                m_ang = d_ang[g]; m_oth = d_oth[g]; m_sel = d_sel[g];
                t = (e + L + 1) % RING;
                inj_v[t] = 1'b1;
                inj_x[t] = $urandom; inj_y[t] = $urandom; inj_a[t] = $urandom;
                exp_v[t] = 1'b1; exp_id[t] = g; exp_sel[t] = d_sel[g];
                last_acc = e;
                acc_cnt[g]++;
            end
        end else begin
            m_ptr = 0; m_since = 0; m_cv = 1'b0; m_rsp = '0; m_err = 1'b0;
            m_ang = '0; m_oth = '0; m_sel = '0; m_x = '0; m_y = '0; m_a = '0; m_rsel = '0;
            last_acc = -1000;
            for (int i = 0; i < RING; i++) exp_v[i] = 1'b0;
            for (int i = 0; i < N; i++) acc_cnt[i] = 0;
        end
        inj_v[slot] = 1'b0;
        exp_v[slot] = 1'b0;
        @(posedge clk);
        #1;
        gcyc = e;
        chk("cordic_valid", 32'(cordic_valid), 32'(m_cv));
        chk("cordic_angle", 32'(cordic_angle), 32'(m_ang));
        chk("cordic_another", 32'(cordic_another), 32'(m_oth));
        chk("cordic_select", 32'(cordic_select), 32'(m_sel));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp));
        chk("rsp_x", rsp_x, m_x);
        chk("rsp_y", rsp_y, m_y);
        chk("rsp_angle", rsp_angle, m_a);
        chk("rsp_select", 32'(rsp_select), 32'(m_rsel));
        chk("busy", 32'(busy), 32'((e - last_acc) <= L));
        chk("err_orphan", 32'(err_orphan), 32'(m_err));
        if (rec && rsp_valid != '0) rsp_q.push_back(rsp_valid);
    endtask

    task automatic do_reset();
        d_rst_n = 1'b0;
        repeat (3) cycle();
        d_rst_n = 1'b1;
    endtask

    task automatic chk_stats();
`ifdef CORDIC_SCHED_STATS_EN
        for (int i = 0; i < N; i++)
            chk("stat_cnt", 32'(stat_cnt[16*i +: 16]), (acc_cnt[i] > 65535) ? 32'hFFFF : 32'(acc_cnt[i]));
`endif
    endtask

    typedef struct {
        logic [3:0] valid;
        logic       hold;
        logic [3:0] ready;
    } vec_t;

    vec_t       tv [19];
    logic [3:0] ord_q [$];
    int         acc_edge, lat, seen;
    bit         found;

    initial begin
        for (int i = 0; i < 8; i++) tv[i] = '{4'hF, 1'b0, 4'(1 << (i % 4))};
        for (int i = 8; i < 11; i++) tv[i] = '{4'hF, 1'b1, 4'b0000};
        tv[11] = '{4'b1111, 1'b0, 4'b0001};
        tv[12] = '{4'b1010, 1'b0, 4'b0010};
        tv[13] = '{4'b1001, 1'b0, 4'b1000};
        tv[14] = '{4'b0000, 1'b0, 4'b0000};
        tv[15] = '{4'b0110, 1'b0, 4'b0010};
        tv[16] = '{4'b0011, 1'b0, 4'b0001};
        tv[17] = '{4'b1000, 1'b1, 4'b0000};
        tv[18] = '{4'b1000, 1'b0, 4'b1000};

        rst_n = 1'b0; hold = 1'b0; req_valid = '0; req_angle = '0; req_another = '0;
        req_select = '0; res_valid_in = 1'b0; res_x = '0; res_y = '0; res_angle = '0;
        gcyc = 0; d_force = 1'b0; d_hold = 1'b0; d_valid = '0; rec = 1'b0;
        for (int i = 0; i < N; i++) begin
            d_ang[i] = 16'(i * 16'h1111 + 1); d_oth[i] = 16'(16'h8000 - i); d_sel[i] = 4'(i + 7);
        end
        for (int i = 0; i < RING; i++) begin
            inj_v[i] = 1'b0; exp_v[i] = 1'b0; inj_x[i] = '0; inj_y[i] = '0; inj_a[i] = '0;
        end
        do_reset();

        // Grant table from a fresh pointer
        rec = 1'b1;
        for (int i = 0; i < 19; i++) begin
            d_valid = tv[i].valid;
            d_hold  = tv[i].hold;
            cycle();
            chk("tbl_ready", 32'(a_ready), 32'(tv[i].ready));
            if (tv[i].ready != '0) ord_q.push_back(tv[i].ready);
        end
        d_valid = '0; d_hold = 1'b0;
        repeat (L + 4) cycle();
        rec = 1'b0;
        chk("rsp_order_len", 32'(rsp_q.size()), 32'(ord_q.size()));
        for (int i = 0; i < ord_q.size() && i < rsp_q.size(); i++)
            chk("rsp_order", 32'(rsp_q[i]), 32'(ord_q[i]));

        // Single op on requester 1 and its end-to-end latency
        do_reset();
        d_valid = 4'b0010; d_ang[1] = 16'd30; d_sel[1] = 4'h0;
        cycle();
        chk("single_ready", 32'(a_ready), 32'h2);
        chk("single_cordic_angle", 32'(cordic_angle), 32'd30);
        acc_edge = gcyc;
        d_valid = '0;
        found = 1'b0; lat = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            cycle();
            if (rsp_valid == 4'b0010) begin found = 1'b1; lat = gcyc - acc_edge; end
        end
        chk("single_rsp_seen", 32'(found), 32'd1);
        chk("single_latency", 32'(lat), 32'(L + 1));
        repeat (4) cycle();

        // Orphan result with an empty tag pipe after the mask has expired
        d_force = 1'b1;
        cycle();
        d_force = 1'b0;
        chk("orphan_no_rsp", 32'(rsp_valid), 32'd0);
        repeat (6) cycle();
        chk("orphan_sticky", 32'(err_orphan), 32'd1);
        do_reset();
        chk("orphan_cleared", 32'(err_orphan), 32'd0);

        // Reset with five ops in flight; stale results must vanish silently
        repeat (L + 2) cycle();
        d_valid = 4'b1111;
        repeat (5) cycle();
        d_valid = '0;
        do_reset();
        seen = 0;
        for (int k = 0; k < L + 6; k++) begin
            cycle();
            if (rsp_valid != '0) seen++;
        end
        chk("rst_no_rsp", 32'(seen), 32'd0);
        chk("rst_no_err", 32'(err_orphan), 32'd0);
        chk("rst_not_busy", 32'(busy), 32'd0);

        // Random traffic against the model
        for (int k = 0; k < 800; k++) begin
            d_valid = 4'($urandom);
            d_hold  = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < N; i++) begin
                d_ang[i] = 16'($urandom); d_oth[i] = 16'($urandom); d_sel[i] = 4'($urandom);
            end
            cycle();
        end
        d_valid = '0; d_hold = 1'b0;
        repeat (L + 4) cycle();
        chk_stats();

`ifdef CORDIC_SCHED_STATS_EN
        do_reset();
        d_valid = 4'b0100;
        repeat (70000) cycle();
        chk_stats();
        chk("stat2_sat", 32'(stat_cnt[47:32]), 32'hFFFF);
        d_valid = '0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
